spi_deserializer: RTL and testbench

SPI_DESERIALIZER -- requirements
Module: spi_deserializer

---
 rtl/spi_deserializer.sv | 153 +++++++++++++++
 tb/tb_spi_deserializer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_deserializer.sv
// SPI slave receive path: synchronizes sclk/mosi into clk, shifts MSB-first words,
// and hands each completed word to a downstream FIFO through a one-entry hold register.
module spi_deserializer #(
    parameter int DATAWIDTH   = 32,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sclk,
    input  logic                 mosi,
    input  logic                 full,
    input  logic                 clr_ovf,
    output logic                 write_en,
    output logic [DATAWIDTH-1:0] write_data,
    output logic                 busy,
    output logic                 frame_err,
    output logic                 overflow
);

    // state    | meaning
    // RX_IDLE  | no bits of a word received yet (bit_cnt = 0)
    // RX_RECV  | partial word in the shifter, idle timer running
    // DR_EMPTY | hold register holds nothing
    // DR_PEND  | hold register holds a word waiting for the FIFO

    localparam int CW = $clog2(DATAWIDTH) + 1;
    localparam int IW = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATAWIDTH - 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(TIMEOUT - 1);

    typedef enum logic {RX_IDLE, RX_RECV} rx_state_t;
    typedef enum logic {DR_EMPTY, DR_PEND} dr_state_t;

    rx_state_t rx_state;
    dr_state_t dr_state;

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] fill;
    logic                   sclk_prev;
    logic                   armed;
    logic [DATAWIDTH-1:0]   shifter;
    logic [DATAWIDTH-1:0]   hold_reg;
    logic [CW-1:0]          bit_cnt;
    logic [IW-1:0]          idle_cnt;

    logic                 sclk_s;
    logic                 mosi_s;
    logic                 rise;
    logic                 word_done;
    logic                 drain;
    logic                 ovf_evt;
    logic [DATAWIDTH-1:0] shift_next;

    assign sclk_s     = sclk_sync[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync[SYNC_STAGES-1];
    assign rise       = armed & sclk_s & ~sclk_prev;
    assign shift_next = {shifter[DATAWIDTH-2:0], mosi_s};
    assign word_done  = rise && (bit_cnt == LAST_BIT);
    assign drain      = (dr_state == DR_PEND) && !full;
    assign ovf_evt    = word_done && (dr_state == DR_PEND) && full;
    assign busy       = (bit_cnt != '0);

    // Edge detection stays disarmed until a real low level of sclk has come through
    // the synchronizer, so an sclk already high at reset release is not an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync <= '0;
            mosi_sync <= '0;
            fill      <= '0;
            sclk_prev <= 1'b0;
            armed     <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
            fill      <= {fill[SYNC_STAGES-2:0], 1'b1};
            sclk_prev <= sclk_s;
            if (fill[SYNC_STAGES-1] && !sclk_s)
                armed <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state  <= RX_IDLE;
            shifter   <= '0;
            bit_cnt   <= '0;
            idle_cnt  <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            if (rise) begin
                shifter  <= shift_next;
                idle_cnt <= '0;
                if (bit_cnt == LAST_BIT) begin
                    bit_cnt  <= '0;
                    rx_state <= RX_IDLE;
                end else begin
                    bit_cnt  <= bit_cnt + CW'(1);
                    rx_state <= RX_RECV;
                end
            end else if (rx_state == RX_RECV) begin
                if (idle_cnt == IDLE_MAX) begin
                    bit_cnt   <= '0;
                    idle_cnt  <= '0;
                    frame_err <= 1'b1;
                    rx_state  <= RX_IDLE;
                end else begin
                    idle_cnt <= idle_cnt + IW'(1);
                end
            end
        end
    end

    // A word completing into an empty hold register with the FIFO ready is written
    // straight through, giving a one-cycle latency from the final edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dr_state   <= DR_EMPTY;
            hold_reg   <= '0;
            write_en   <= 1'b0;
            write_data <= '0;
            overflow   <= 1'b0;
        end else begin
            write_en <= 1'b0;
            if (ovf_evt)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;

            if (dr_state == DR_EMPTY) begin
                if (word_done) begin
                    if (!full) begin
                        write_en   <= 1'b1;
                        write_data <= shift_next;
                    end else begin
                        hold_reg <= shift_next;
                        dr_state <= DR_PEND;
                    end
                end
            end else if (drain) begin
                write_en   <= 1'b1;
                write_data <= hold_reg;
                if (word_done)
                    hold_reg <= shift_next;
                else
                    dr_state <= DR_EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_spi_deserializer.sv
// Randomized bench for spi_deserializer: drives SPI frames from clk negedges and
// checks every FIFO write against a queue-based model of the one-entry hold stage.
module tb_spi_deserializer;

    localparam int DW = 32;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic          sclk;
    logic          mosi;
    logic          full;
    logic          clr_ovf;
    logic          write_en;
    logic [DW-1:0] write_data;
    logic          busy;
    logic          frame_err;
    logic          overflow;

    always #5 clk = ~clk;

    spi_deserializer #(.DATAWIDTH(DW), .SYNC_STAGES(2), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .sclk       (sclk),
        .mosi       (mosi),
        .full       (full),
        .clr_ovf    (clr_ovf),
        .write_en   (write_en),
        .write_data (write_data),
        .busy       (busy),
        .frame_err  (frame_err),
        .overflow   (overflow)
    );

    int n_chk = 0;
    int n_err = 0;
    int n_wr  = 0;
    int n_ferr = 0;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_hold;
    bit            m_hold_valid = 0;
    bit            m_ovf = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (write_en) begin
                n_wr++;
                chk("wr_expected", DW'(exp_q.size() != 0), DW'(1));
                if (exp_q.size() != 0)
                    chk("wr_data", write_data, exp_q.pop_front());
            end
            if (frame_err)
                n_ferr++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One-entry hold stage: while full, the first word waits and later ones are lost.
    task automatic model_word(input logic [DW-1:0] w);
        if (full) begin
            if (!m_hold_valid) begin
                m_hold       = w;
                m_hold_valid = 1;
            end else begin
                m_ovf = 1;
            end
        end else begin
            exp_q.push_back(w);
        end
    endtask

    task automatic set_full(input logic v);
        full = v;
        if (!v && m_hold_valid) begin
            exp_q.push_back(m_hold);
            m_hold_valid = 0;
        end
        cyc(3);
    endtask

    task automatic send_bits(input logic [DW-1:0] w, input int nbits, input int lo,
                             input int hi, input bit chk_lat);
        for (int i = 0; i < nbits; i++) begin
            sclk = 1'b0;
            mosi = w[DW-1-i];
            cyc(lo);
            sclk = 1'b1;
            if (i == DW - 1)
                model_word(w);
            if (chk_lat && i == DW - 1) begin
                cyc(2);
                chk("lat_we_early", DW'(write_en), DW'(0));
                chk("lat_busy_hold", DW'(busy), DW'(1));
                cyc(1);
                chk("lat_we", DW'(write_en), DW'(1));
                chk("lat_busy_fall", DW'(busy), DW'(0));
                chk("lat_data", write_data, w);
                if (hi > 3)
                    cyc(hi - 3);
            end else begin
                cyc(hi);
            end
        end
    endtask

    task automatic send_word(input logic [DW-1:0] w, input int lo, input int hi);
        send_bits(w, DW, lo, hi, 1'b0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wr0;
        int f0;
        rst = 1'b1; sclk = 1'b0; mosi = 1'b0; full = 1'b0; clr_ovf = 1'b0;
        cyc(3);
        chk("rst_we", DW'(write_en), DW'(0));
        chk("rst_wdata", write_data, DW'(0));
        chk("rst_busy", DW'(busy), DW'(0));
        chk("rst_ferr", DW'(frame_err), DW'(0));
        chk("rst_ovf", DW'(overflow), DW'(0));
        rst = 1'b0;
        cyc(4);

        // single word at minimum period, with latency check on the last edge
        send_bits(32'hA5C3_0F81, DW, 2, 2, 1'b1);
        cyc(5);
        chk("single_count", n_wr, 1);

        // word held while FIFO full, released later
        set_full(1'b1);
        send_word(32'h1234_5678, 2, 3);
        cyc(20);
        chk("full_no_write", n_wr, 1);
        set_full(1'b0);
        cyc(3);
        chk("full_release_count", n_wr, 2);
        chk("full_no_ovf", DW'(overflow), DW'(0));

        // second word while hold occupied is dropped
        set_full(1'b1);
        send_word(32'h1111_1111, 2, 2);
        cyc(3);
        send_word(32'h2222_2222, 2, 2);
        cyc(5);
        chk("ovf_set", DW'(overflow), DW'(m_ovf));
        set_full(1'b0);
        cyc(5);
        chk("ovf_drain_count", n_wr, 3);
        clr_ovf = 1'b1;
        cyc(1);
        clr_ovf = 1'b0;
        m_ovf = 0;
        chk("ovf_clear", DW'(overflow), DW'(0));

        // partial word abandoned by timeout
        f0 = n_ferr;
        send_bits($urandom, 10, 2, 2, 1'b0);
        chk("partial_busy", DW'(busy), DW'(1));
        cyc(TO + 10);
        chk("timeout_ferr", n_ferr, f0 + 1);
        chk("timeout_busy", DW'(busy), DW'(0));
        wr0 = n_wr;
        send_word(32'h0F0F_3C3C, 2, 2);
        cyc(5);
        chk("after_timeout_count", n_wr, wr0 + 1);

        // reset in the middle of a word
        f0 = n_ferr;
        send_bits(32'hFFFF_FFFF, 17, 2, 2, 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_we", DW'(write_en), DW'(0));
        chk("midrst_wdata", write_data, DW'(0));
        chk("midrst_busy", DW'(busy), DW'(0));
        chk("midrst_ferr", DW'(frame_err), DW'(0));
        chk("midrst_ovf", DW'(overflow), DW'(0));
        exp_q.delete();
        m_hold_valid = 0;
        m_ovf = 0;
        cyc(2);
        rst = 1'b0;
        cyc(10);
        chk("sclk_high_no_edge", DW'(busy), DW'(0));
        wr0 = n_wr;
        send_word(32'hDEAD_BEEF, 2, 2);
        cyc(5);
        chk("midrst_word_count", n_wr, wr0 + 1);
        chk("midrst_no_ferr", n_ferr, f0);

        // back-to-back words at minimum period
        wr0 = n_wr;
        for (int k = 0; k < 16; k++)
            send_word($urandom, 2, 2);
        cyc(6);
        chk("b2b_count", n_wr, wr0 + 16);
        chk("b2b_no_ovf", DW'(overflow), DW'(0));

        // random periods with random FIFO backpressure between words
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                cyc(2);
                set_full(~full);
            end
            send_word($urandom, $urandom_range(2, 4), $urandom_range(2, 4));
        end
        cyc(3);
        set_full(1'b0);
        cyc(10);
        chk("rand_ovf", DW'(overflow), DW'(m_ovf));
        chk("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
